// File: rtl/h264nzstore.sv
// total_coeff context store for CAVLC: keeps the current-MB, left-column and top-line nC sources and
// predicts nC for block (NX,NY). Define H264NZ_NINREG_EN for a registered NIN (1-cycle latency).
module h264nzstore #(
    parameter int unsigned MAXMBW = 120
) (
    input  logic       CLK,
    input  logic       NRESET,
    input  logic       NEWLINE,
    input  logic [2:0] NX,
    input  logic [2:0] NY,
    input  logic [1:0] NV,
    input  logic       NLOAD,
    input  logic [4:0] NOUT,
    input  logic       NXINC,
    output logic [4:0] NIN
);

    localparam int unsigned NW     = 5;
    localparam int unsigned CUR_N  = 24;
    localparam int unsigned SIDE_N = 8;
    localparam int unsigned MBXW   = (MAXMBW > 1) ? $clog2(MAXMBW) : 1;
    localparam logic [MBXW-1:0] MBX_MAX = MBXW'(MAXMBW - 1);

    // Current MB: luma at {y,x}, chroma at 16+{plane,y,x}
    logic [NW-1:0]   cur      [CUR_N];
    logic [NW-1:0]   cur_eff  [CUR_N];
    // Left column / top row: luma at y (or x), chroma at 4+{plane,y (or x)}
    logic [NW-1:0]   left_st  [SIDE_N];
    logic [NW-1:0]   top_mem  [MAXMBW][SIDE_N];
    logic [MBXW-1:0] mbx;

    logic            chroma;
    logic            plane;
    logic [4:0]      wr_idx;
    logic            x_gt0;
    logic            y_gt0;
    logic [1:0]      lx;
    logic [1:0]      ty;
    logic [2:0]      left_idx;
    logic [2:0]      top_idx;
    logic [NW-1:0]   l_val;
    logic [NW-1:0]   t_val;
    logic [5:0]      sum;
    logic [NW-1:0]   nc_c;

    function automatic logic [4:0] blk_idx(input logic c, input logic p,
                                           input logic [1:0] x, input logic [1:0] y);
        if (c) begin
            return 5'd16 + 5'({p, y[0], x[0]});
        end
        return 5'({1'b0, y, x});
    endfunction

    assign chroma = NX[2] & NY[2];
    assign plane  = NX[1];
    assign wr_idx = blk_idx(chroma, plane, NX[1:0], NY[1:0]);

    // Store view with this cycle's NLOAD applied, shared by lookup and NXINC copies
    always_comb begin
        cur_eff = cur;
        if (NLOAD) begin
            cur_eff[wr_idx] = NOUT;
        end
    end

    always_comb begin
        x_gt0    = chroma ? NX[0] : (NX[1:0] != 2'd0);
        y_gt0    = chroma ? NY[0] : (NY[1:0] != 2'd0);
        lx       = chroma ? 2'd0 : (NX[1:0] - 2'd1);
        ty       = chroma ? 2'd0 : (NY[1:0] - 2'd1);
        left_idx = chroma ? {1'b1, plane, NY[0]} : {1'b0, NY[1:0]};
        top_idx  = chroma ? {1'b1, plane, NX[0]} : {1'b0, NX[1:0]};
        l_val    = x_gt0 ? cur_eff[blk_idx(chroma, plane, lx, NY[1:0])] : left_st[left_idx];
        t_val    = y_gt0 ? cur_eff[blk_idx(chroma, plane, NX[1:0], ty)] : top_mem[mbx][top_idx];
        sum      = 6'(l_val) + 6'(t_val) + 6'd1;
        nc_c     = '0;
        case (NV)
            2'b01:   nc_c = l_val;
            2'b10:   nc_c = t_val;
            2'b11:   nc_c = NW'(sum >> 1);
            default: nc_c = '0;
        endcase
    end

    // Current MB, left column and macroblock position
    always_ff @(posedge CLK) begin
        if (!NRESET) begin
            mbx <= '0;
            for (int i = 0; i < int'(CUR_N); i++) begin
                cur[i] <= '0;
            end
            for (int i = 0; i < int'(SIDE_N); i++) begin
                left_st[i] <= '0;
            end
        end else begin
            if (NLOAD) begin
                cur[wr_idx] <= NOUT;
            end
            if (NXINC) begin
                for (int i = 0; i < 4; i++) begin
                    left_st[3'(i)]     <= cur_eff[5'(4 * i + 3)];
                    left_st[3'(4 + i)] <= cur_eff[5'(16 + 2 * i + 1)];
                end
            end
            if (NEWLINE) begin
                mbx <= '0;
            end else if (NXINC && (mbx != MBX_MAX)) begin
                mbx <= mbx + MBXW'(1);
            end
        end
    end

    // Bottom row into the line buffer at the pre-increment mbx; contents never reset
    always_ff @(posedge CLK) begin
        if (NRESET && NXINC) begin
            for (int i = 0; i < 4; i++) begin
                top_mem[mbx][3'(i)]     <= cur_eff[5'(12 + i)];
                top_mem[mbx][3'(4 + i)] <= cur_eff[5'(18 + 4 * (i / 2) + (i % 2))];
            end
        end
    end

`ifdef H264NZ_NINREG_EN
    always_ff @(posedge CLK) begin
        if (!NRESET) begin
            NIN <= '0;
        end else begin
            NIN <= nc_c;
        end
    end
`else
    always_comb begin
        NIN = '0;
        if (NRESET) begin
            NIN = nc_c;
        end
    end
`endif

endmodule

// File: tb/tb_h264nzstore.sv
// Directed bench for h264nzstore; follows H264NZ_NINREG_EN to pick the NIN read latency.
module tb_h264nzstore;

    logic       clk = 1'b0;
    logic       nreset;
    logic       newline;
    logic [2:0] nx;
    logic [2:0] ny;
    logic [1:0] nv;
    logic       nload;
    logic [4:0] nout;
    logic       nxinc;
    logic [4:0] nin;

    int checks   = 0;
    int failures = 0;

    h264nzstore #(.MAXMBW(120)) dut (
        .CLK    (clk),
        .NRESET (nreset),
        .NEWLINE(newline),
        .NX     (nx),
        .NY     (ny),
        .NV     (nv),
        .NLOAD  (nload),
        .NOUT   (nout),
        .NXINC  (nxinc),
        .NIN    (nin)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] x, input logic [2:0] y, input logic [4:0] v);
        nx    = x;
        ny    = y;
        nout  = v;
        nload = 1'b1;
        tick();
        nload = 1'b0;
    endtask

    task automatic xinc();
        nxinc = 1'b1;
        tick();
        nxinc = 1'b0;
    endtask

    task automatic query(input string tag, input logic [2:0] x, input logic [2:0] y,
                         input logic [1:0] v, input logic [4:0] exp);
        nx = x;
        ny = y;
        nv = v;
`ifdef H264NZ_NINREG_EN
        tick();
`else
        #1;
`endif
        check_val(tag, nin, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset  = 1'b0;
        newline = 1'b0;
        nx      = '0;
        ny      = '0;
        nv      = '0;
        nload   = 1'b0;
        nout    = '0;
        nxinc   = 1'b0;
        tick();
        tick();
        check_val("rst_nin", nin, 5'd0);
        nreset = 1'b1;

        query("nv00", 3'd0, 3'd0, 2'b00, 5'd0);
        load(3'd0, 3'd0, 5'd7);
        query("left_in_mb", 3'd1, 3'd0, 2'b01, 5'd7);

        load(3'd0, 3'd1, 5'd4);
        load(3'd1, 3'd0, 5'd9);
        query("avg", 3'd1, 3'd1, 2'b11, 5'd7);
        query("top_in_mb", 3'd1, 3'd1, 2'b10, 5'd9);
        query("left_only", 3'd1, 3'd1, 2'b01, 5'd4);

        // Average upper bound: (16+15+1)>>1 and (16+16+1)>>1
        load(3'd2, 3'd1, 5'd16);
        load(3'd3, 3'd0, 5'd15);
        query("avg_31", 3'd3, 3'd1, 2'b11, 5'd16);
        load(3'd3, 3'd0, 5'd16);
        query("avg_32", 3'd3, 3'd1, 2'b11, 5'd16);

        load(3'b100, 3'b100, 5'd6);
        query("cb_left", 3'b101, 3'b100, 2'b01, 5'd6);
        query("cb_top", 3'b100, 3'b101, 2'b10, 5'd6);

        // MB0 right column {1,2,3,4}, bottom-left 5, Cb(1,1)=3
        load(3'd3, 3'd0, 5'd1);
        load(3'd3, 3'd1, 5'd2);
        load(3'd3, 3'd2, 5'd3);
        load(3'd3, 3'd3, 5'd4);
        load(3'd0, 3'd3, 5'd5);
        load(3'b101, 3'b101, 5'd3);
        xinc();
        query("left_store_y2", 3'd0, 3'd2, 2'b01, 5'd3);
        query("left_store_y3", 3'd0, 3'd3, 2'b01, 5'd4);

        newline = 1'b1;
        tick();
        newline = 1'b0;
        query("top_line_x0", 3'd0, 3'd0, 2'b10, 5'd5);

        // Last Cr block written in the same cycle as NXINC (mbx 0 -> 1)
        nx    = 3'b111;
        ny    = 3'b111;
        nout  = 5'd12;
        nload = 1'b1;
        nxinc = 1'b1;
        tick();
        nload = 1'b0;
        nxinc = 1'b0;
        query("cr_bypass_left", 3'b110, 3'b111, 2'b01, 5'd12);
        query("cb_store_left", 3'b100, 3'b101, 2'b01, 5'd3);

        // NEWLINE+NXINC: copies land at old mbx=1, mbx ends at 0
        load(3'd0, 3'd3, 5'd8);
        newline = 1'b1;
        nxinc   = 1'b1;
        tick();
        newline = 1'b0;
        nxinc   = 1'b0;
        query("newline_mbx0", 3'd0, 3'd0, 2'b10, 5'd5);
        query("cr_top_line", 3'b111, 3'b110, 2'b10, 5'd12);
        query("cb_top_line", 3'b101, 3'b100, 2'b10, 5'd3);
        xinc();
        query("old_mbx_copy", 3'd0, 3'd0, 2'b10, 5'd8);
        query("left_store_y0", 3'd0, 3'd0, 2'b01, 5'd1);

        // Drive mbx well past the end; it must hold at MAXMBW-1
        repeat (125) xinc();
        load(3'd0, 3'd3, 5'd11);
        xinc();
        query("mbx_saturate", 3'd0, 3'd0, 2'b10, 5'd11);

        query("pre_reset", 3'd1, 3'd0, 2'b01, 5'd7);
        nreset = 1'b0;
        tick();
        check_val("reset_nin", nin, 5'd0);
        nreset = 1'b1;
        query("reset_left", 3'd0, 3'd0, 2'b01, 5'd0);
        query("reset_cur", 3'd1, 3'd0, 2'b01, 5'd0);

        nreset = 1'b0;
        nx     = 3'd0;
        ny     = 3'd0;
        nout   = 5'd15;
        nload  = 1'b1;
        tick();
        nload  = 1'b0;
        nreset = 1'b1;
        query("reset_drops_load", 3'd1, 3'd0, 2'b01, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
